// File: rtl/bus_dma_master.sv
// Single-master block copy engine: reads one word from src+i, writes it to dst+i, repeats.
// A grant loss during a read or write sends the current word back through REQ.
module bus_dma_master #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [15:0]      src_addr,
  input  logic [15:0]      dst_addr,
  input  logic [LEN_W-1:0] length,
  input  logic             m_grant,
  input  logic [63:0]      m_din,
  output logic             m_req,
  output logic             m_wr,
  output logic [15:0]      m_addr,
  output logic [31:0]      m_dout,
  output logic             busy,
  output logic             done
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StRd,
    StCap,
    StWr,
    StDone
  } state_e;

  state_e           r_state;
  state_e           w_state_d;
  logic [15:0]      r_src;
  logic [15:0]      w_src_d;
  logic [15:0]      r_dst;
  logic [15:0]      w_dst_d;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] w_len_d;
  logic [LEN_W-1:0] r_idx;
  logic [LEN_W-1:0] w_idx_d;
  logic [31:0]      r_data;
  logic [31:0]      w_data_d;

  logic [15:0]      w_src_cur;
  logic [15:0]      w_dst_cur;
  logic             w_last;
  logic             w_unused_din;

  // Addresses wrap naturally at 16 bits.
  assign w_src_cur    = r_src + 16'(r_idx);
  assign w_dst_cur    = r_dst + 16'(r_idx);
  assign w_last       = (r_idx == (r_len - LEN_W'(1)));
  assign w_unused_din = ^m_din[63:32];

  // Write data only changes at the end of CAP, so it holds its value outside WR.
  assign m_dout = r_data;

  always_comb begin
    w_state_d = r_state;
    w_src_d   = r_src;
    w_dst_d   = r_dst;
    w_len_d   = r_len;
    w_idx_d   = r_idx;
    w_data_d  = r_data;
    m_req     = 1'b0;
    m_wr      = 1'b0;
    m_addr    = 16'h0000;
    busy      = 1'b1;
    done      = 1'b0;

    case (r_state)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          w_src_d   = src_addr;
          w_dst_d   = dst_addr;
          w_len_d   = length;
          w_idx_d   = '0;
          w_state_d = (length == '0) ? StDone : StReq;
        end
      end

      StReq: begin
        m_req = 1'b1;
        if (m_grant) begin
          w_state_d = StRd;
        end
      end

      StRd: begin
        m_req     = 1'b1;
        m_addr    = w_src_cur;
        w_state_d = m_grant ? StCap : StReq;
      end

      StCap: begin
        m_req  = 1'b1;
        m_addr = w_src_cur;
        if (m_grant) begin
          w_data_d  = m_din[31:0];
          w_state_d = StWr;
        end else begin
          w_state_d = StReq;
        end
      end

      StWr: begin
        m_req  = 1'b1;
        m_wr   = 1'b1;
        m_addr = w_dst_cur;
        if (!m_grant) begin
          // Void write: redo the whole word, read included.
          w_state_d = StReq;
        end else if (w_last) begin
          w_state_d = StDone;
        end else begin
          w_idx_d   = r_idx + LEN_W'(1);
          w_state_d = StRd;
        end
      end

      StDone: begin
        done      = 1'b1;
        w_state_d = StIdle;
      end

      default: begin
        busy      = 1'b0;
        w_state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= StIdle;
      r_src   <= 16'h0000;
      r_dst   <= 16'h0000;
      r_len   <= '0;
      r_idx   <= '0;
      r_data  <= 32'h0000_0000;
    end else begin
      r_state <= w_state_d;
      r_src   <= w_src_d;
      r_dst   <= w_dst_d;
      r_len   <= w_len_d;
      r_idx   <= w_idx_d;
      r_data  <= w_data_d;
    end
  end

endmodule

// File: doc/bus_dma_master.md
Name: bus_dma_master

Overview:
- Single bus master that performs block word copies between slave address ranges.
- Connects directly upstream of the system bus, on the master side.
- Drives m_req, m_wr, m_addr and m_dout; consumes m_grant and m_din.
- Configured by a start pulse carrying source address, destination address and word count. Reports busy/done.

Parameters:
- LEN_W, 8, width of the word-count input (maximum transfer = 2^LEN_W - 1 words)

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle command strobe; sampled only in IDLE
- src_addr  input  16  first source word address
- dst_addr  input  16  first destination word address
- length  input  LEN_W  number of words to copy
- m_grant  input  1  bus grant from arbiter
- m_din  input  64  read data from bus; valid the cycle after a read address cycle
- m_req  output  1  bus request
- m_wr  output  1  1 = write, 0 = read
- m_addr  output  16  bus address
- m_dout  output  32  write data
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0; state IDLE; internal counters and registers 0. Reset is asynchronous: it clears everything immediately, including mid-transfer. No partial-state recovery; the interrupted transfer is abandoned.
- In IDLE, start=1 latches src_addr, dst_addr and length, and clears word index i to 0.
  - length=0: go to DONE (no bus request).
  - Otherwise: go to REQ.
- start in any state other than IDLE is ignored.
- REQ: m_req=1, m_wr=0, m_addr=0. Stay until m_grant=1, then go to RD.
- RD: m_req=1, m_wr=0, m_addr=src+i (16-bit modulo). Next state CAP.
- CAP: m_req=1, m_wr=0, m_addr=src+i held. Latch data_reg <= m_din[31:0]; m_din[63:32] is discarded. Next state WR.
- WR: m_req=1, m_wr=1, m_addr=dst+i (modulo 2^16), m_dout=data_reg.
  - If i == length-1: go to DONE.
  - Otherwise: i <= i+1 and go to RD.
- DONE: done=1 for exactly one cycle, m_req=0, m_wr=0; next state IDLE.
- busy=1 in REQ, RD, CAP, WR and DONE; 0 in IDLE.
- Grant loss: if m_grant=0 while in RD, CAP or WR, that cycle's bus action is void.
  - FSM returns to REQ with i unchanged.
  - After regrant, the current word restarts from RD (read repeated, never a write with stale data).
- Throughput: after the first grant, 3 cycles per word.
- Bus read latency is fixed at 1 cycle: data addressed in RD is sampled in CAP.
- m_dout holds its last value outside WR; it is 0 after reset.
- Address wrap: src+i and dst+i wrap 0xFFFF -> 0x0000 silently.
- Overlapping src/dst ranges: no special handling; copy proceeds in ascending address order.

Test Plan:
- Reset, then idle: reset_n low mid-run, then high -> all outputs 0, busy=0; no m_req with start=0.
- Single word: src=0x0010, dst=0x0020, length=1, slave returns 0x0000_0000_CAFE_BABE -> read at 0x0010, then write 0xCAFEBABE at 0x0020 with m_wr=1. done pulses once, 1 cycle after WR.
- Four-word burst: src=0x0100, dst=0x0200, length=4, grant 1 cycle after req -> reads 0x0100..0x0103, writes 0x0200..0x0203 in the matching order. done pulses 1 + 1 + 12 + 1 cycles after the start cycle.
- Zero length and start while busy: length=0 -> done pulse 1 cycle after start with m_req never high. A second start during a transfer -> no effect on the addresses or count in use.
- Grant drop and reset mid-run:
  - Deassert m_grant during CAP of word 2 -> FSM returns to REQ; word 2 is re-read after regrant; destination receives each word exactly once.
  - Assert reset_n=0 during WR -> m_req, m_wr and busy go 0 immediately (asynchronously).
- Wrap: src=0xFFFE, dst=0x7FFF, length=3 -> read addresses 0xFFFE, 0xFFFF, 0x0000; write addresses 0x7FFF, 0x8000, 0x8001.
